// File: rtl/viterbi_pkg.sv
// Shared constants for the Viterbi test chain: default generators, word geometry
// and the encoder FSM state encoding.
package viterbi_pkg;

  localparam int K            = 3;
  localparam int SYM_PER_WORD = 8;
  localparam int WORD_W       = 16;

  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

endpackage

// File: rtl/conv_enc_core.sv
// One combinational step of the K=3 convolutional encoder: input bit plus state
// in, {c0,c1} symbol and next state out. Shared with the decoder-side model.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic         u,
  input  logic [1:0]   sr,
  input  logic [K-1:0] g0,
  input  logic [K-1:0] g1,
  output logic [1:0]   sym,
  output logic [1:0]   sr_next
);

  logic [K-1:0] taps;

  // Tap vector ordering matches the generator bit mapping: current, sr[0], sr[1].
  assign taps    = {u, sr[0], sr[1]};
  assign sym     = {^(taps & g0), ^(taps & g1)};
  assign sr_next = {sr[0], u};

endmodule

// File: rtl/conv_encode_pack.sv
// Rate-1/2 encoder that packs one byte into a 16-bit word of 8 symbols and
// presents it for exactly 8 extraction-enable cycles.
module conv_encode_pack
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  input  logic        i_sof,
  output logic        o_ready,
  output logic [15:0] o_data,
  output logic        o_en_ext,
  output logic        o_busy
);

  localparam logic [2:0] LAST_SYM = 3'(SYM_PER_WORD - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] sr_q, sr_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] cnt_q, cnt_d;
  word_t      word_q, word_d;
  word_t      data_q, data_d;

  logic [1:0] sym;
  logic [1:0] sr_step;

  conv_enc_core u_core (
    .u       (byte_q[7]),
    .sr      (sr_q),
    .g0      (G0),
    .g1      (G1),
    .sym     (sym),
    .sr_next (sr_step)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          byte_d  = i_byte;
          cnt_d   = 3'd0;
          state_d = ST_ENC;
          if (i_sof) sr_d = 2'b00;
        end
      end
      ST_ENC: begin
        sr_d   = sr_step;
        byte_d = {byte_q[6:0], 1'b0};
        word_d = {word_q[13:0], sym};
        cnt_d  = cnt_q + 3'd1;
        // The last symbol is folded straight into o_data so EMIT starts next cycle.
        if (cnt_q == LAST_SYM) begin
          data_d  = {word_q[13:0], sym};
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_SYM) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sr_q    <= 2'b00;
      byte_q  <= 8'h00;
      cnt_q   <= 3'd0;
      word_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_en_ext = (state_q == ST_EMIT);
  assign o_data   = data_q;

endmodule

// File: doc/conv_encode_pack.md
Name: conv_encode_pack

Overview:
- Rate-1/2, K=3 convolutional encoder; sits directly upstream of the 2-bit symbol extraction stage of the Viterbi test chain.
- Accepts one data byte per handshake and encodes it MSB-first, one bit per clock.
- Packs the 8 resulting 2-bit symbols into a 16-bit word, first symbol in bits [15:14].
- Then drives the word plus an 8-cycle extraction-enable window, so the downstream MSB-to-LSB extractor consumes exactly one word per window.

Parameters:
- G0, 3'b111, generator polynomial for first code bit c0 (bit2 = current input, bit1 = sr[0], bit0 = sr[1]).
- G1, 3'b101, generator polynomial for second code bit c1 (same bit mapping).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- i_byte  input  8  data byte to encode, b7 encoded first.
- i_valid  input  1  i_byte valid; accepted when i_valid && o_ready at a rising edge.
- i_sof  input  1  sampled with accepted byte; 1 = clear encoder state to 00 before encoding this byte.
- o_ready  output  1  high only in IDLE.
- o_data  output  16  packed codeword, held stable for whole EMIT window.
- o_en_ext  output  1  extraction enable, high exactly 8 consecutive cycles per word.
- o_busy  output  1  high in ENC and EMIT.

Behaviour:
- Reset (rst=0, async): state=IDLE, sr=2'b00, bit counter=0, o_data=16'h0000, o_en_ext=0, o_busy=0, o_ready=1. Reset mid-ENC/EMIT aborts: partial word discarded, o_en_ext drops immediately.
- Encoder: sr[0] = previous input bit, sr[1] = bit before that. Per bit u: c0 = ^({u,sr[0],sr[1]} & G0), c1 = ^({u,sr[0],sr[1]} & G1); then sr <= {sr[0],u}. Symbol k (k=0 for b7 .. k=7 for b0) written to word bits [15-2k:14-2k] as {c0,c1}.
- sr persists across bytes unless i_sof=1 on the accepted byte.
- FSM:
  - IDLE: on accept at edge T, latch byte/i_sof; if i_sof, sr<=00; -> ENC.
  - ENC: cycles T+1..T+8, one bit per cycle into an internal shift word. o_data keeps its previous value.
  - EMIT: at edge T+8, o_data <= completed word. o_en_ext=1 during cycles T+9..T+16. At edge T+16 -> IDLE. o_ready=1 from cycle T+17.
- Latency: accept -> first o_en_ext cycle = 9 clocks. Throughput: one byte per 17 cycles.
- i_valid while o_ready=0 is ignored, no queuing. Upstream must hold i_valid until accepted.
- i_sof is ignored unless its byte is accepted.
- o_data remains at the last word after EMIT until the next EMIT; o_en_ext=0 outside EMIT.
- Window alignment: the downstream extractor's 4-bit index starts at 15 and wraps after exactly 8 enables. Every window must therefore be exactly 8 cycles; no pause or early exit except reset.

Decomposition:
- Shared package viterbi_pkg: G0_DEF=3'b111, G1_DEF=3'b101, K=3, SYM_PER_WORD=8, WORD_W=16, FSM state encoding (IDLE, ENC, EMIT).
- One natural sub-module: conv_enc_core, a combinational one-bit step taking (u, sr, G0, G1) and returning ({c0,c1}, next sr). The decoder-side reference model reuses it.

Test Plan:
- Reset, then byte 8'h80 with i_sof=1 -> o_data=16'hEC00; o_en_ext high exactly cycles T+9..T+16; o_ready returns at T+17.
- 8'hFF with i_sof=1 -> 16'hDAAA. Then 8'h00 with i_sof=0 -> 16'h7000. Repeat 8'h00 with i_sof=1 -> 16'h0000.
- Hold i_valid high continuously with changing bytes -> accepts only in IDLE, one byte per 17 cycles; bytes presented while busy are not accepted.
- Assert rst low during ENC (cycle T+4) -> outputs clear immediately, o_ready=1; next byte 8'h80 with i_sof=0 -> 16'hEC00 (sr cleared by reset).
- Chain with the extraction stage, 4 back-to-back words -> extractor emits 32 symbols matching o_data MSB pair first, and its index equals 15 at the start of every window.
- Non-default G0=3'b110, G1=3'b011, byte 8'h80 with i_sof=1 -> symbols 10,11,01,00.. -> o_data=16'hB400.
